// File: rtl/clock_display_scanner_if.sv
// Time/alarm inputs and display/buzzer outputs between the alarm clock core
// and the display scanner.
interface clock_display_scanner_if;
    logic [3:0] hr_in;
    logic [5:0] min_in;
    logic [5:0] sec_in;
    logic [3:0] hr_alarm_in;
    logic [5:0] min_alarm_in;
    logic       alarm_in;
    logic       show_alarm;
    logic       ack;
    logic [5:0] digit_sel;
    logic [6:0] seg;
    logic       dp;
    logic       buzzer;

    modport master (
        output hr_in, min_in, sec_in, hr_alarm_in, min_alarm_in,
        output alarm_in, show_alarm, ack,
        input  digit_sel, seg, dp, buzzer
    );

    modport slave (
        input  hr_in, min_in, sec_in, hr_alarm_in, min_alarm_in,
        input  alarm_in, show_alarm, ack,
        output digit_sel, seg, dp, buzzer
    );
endinterface

// File: rtl/clock_display_scanner.sv
// Six-digit multiplexed seven-segment display driver with blinking colon,
// plus an acknowledgeable alarm buzzer.
module clock_display_scanner #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned TONE_DIV = 500
) (
    input logic                    clk,
    input logic                    rst_n,
    clock_display_scanner_if.slave bus
);
    localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
    localparam int unsigned TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RINGING,
        ST_ACKED
    } alarm_state_e;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    logic [SLOT_W-1:0] r_slot;
    logic [2:0]        r_idx;
    logic [3:0]        r_snap_hr;
    logic [5:0]        r_snap_min;
    logic [5:0]        r_snap_sec;
    logic              r_snap_alarm;
    logic [5:0]        r_sec_q;
    logic              r_colon;
    logic [5:0]        r_digit_sel;
    logic [6:0]        r_seg;
    logic              r_dp;

    alarm_state_e      r_state;
    logic              r_alarm_q;
    logic              r_ack_q;
    logic              r_armed;
    logic [TONE_W-1:0] r_tone;
    logic              r_buzzer;

    logic       w_hr_ok;
    logic       w_min_ok;
    logic       w_sec_ok;
    logic [3:0] w_hr_tens;
    logic [3:0] w_hr_ones;
    logic [3:0] w_min_tens;
    logic [3:0] w_min_ones;
    logic [3:0] w_sec_tens;
    logic [3:0] w_sec_ones;
    logic [6:0] w_seg;
    logic       w_dp;
    logic       w_alarm_rise;
    logic       w_alarm_fall;
    logic       w_ack_rise;

    // BCD split, validation and segment selection for the digit being scanned
    always_comb begin
        w_hr_ok    = (r_snap_hr != 4'd0) && (r_snap_hr <= 4'd12);
        w_min_ok   = (r_snap_min <= 6'd59);
        w_sec_ok   = (r_snap_sec <= 6'd59);
        w_hr_tens  = 4'(r_snap_hr / 4'd10);
        w_hr_ones  = 4'(r_snap_hr % 4'd10);
        w_min_tens = 4'(r_snap_min / 6'd10);
        w_min_ones = 4'(r_snap_min % 6'd10);
        w_sec_tens = 4'(r_snap_sec / 6'd10);
        w_sec_ones = 4'(r_snap_sec % 6'd10);
        w_seg      = SEG_BLANK;
        case (r_idx)
            3'd0: w_seg = r_snap_alarm ? SEG_BLANK : (w_sec_ok ? seg_code(w_sec_ones) : SEG_DASH);
            3'd1: w_seg = r_snap_alarm ? SEG_BLANK : (w_sec_ok ? seg_code(w_sec_tens) : SEG_DASH);
            3'd2: w_seg = w_min_ok ? seg_code(w_min_ones) : SEG_DASH;
            3'd3: w_seg = w_min_ok ? seg_code(w_min_tens) : SEG_DASH;
            3'd4: w_seg = w_hr_ok ? seg_code(w_hr_ones) : SEG_DASH;
            3'd5: w_seg = !w_hr_ok ? SEG_DASH :
                          ((r_snap_hr < 4'd10) ? SEG_BLANK : seg_code(w_hr_tens));
            default: w_seg = SEG_BLANK;
        endcase
        w_dp = 1'b0;
        if ((r_idx == 3'd2) || (r_idx == 3'd4)) begin
            w_dp = r_snap_alarm ? 1'b1 : r_colon;
        end
    end

    // Slot/digit scan counters, frame snapshot and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot       <= '0;
            r_idx        <= 3'd0;
            r_snap_hr    <= 4'd12;
            r_snap_min   <= 6'd0;
            r_snap_sec   <= 6'd0;
            r_snap_alarm <= 1'b0;
            r_digit_sel  <= 6'd0;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b0;
        end else begin
            r_digit_sel <= (r_slot == SLOT_LAST) ? 6'd0 : (6'd1 << r_idx);
            r_seg       <= w_seg;
            r_dp        <= w_dp;
            if (r_slot == SLOT_LAST) begin
                r_slot <= '0;
                if (r_idx == 3'd5) begin
                    r_idx        <= 3'd0;
                    r_snap_alarm <= bus.show_alarm;
                    if (bus.show_alarm) begin
                        r_snap_hr  <= bus.hr_alarm_in;
                        r_snap_min <= bus.min_alarm_in;
                        r_snap_sec <= 6'd0;
                    end else begin
                        r_snap_hr  <= bus.hr_in;
                        r_snap_min <= bus.min_in;
                        r_snap_sec <= bus.sec_in;
                    end
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end else begin
                r_slot <= r_slot + 1'b1;
            end
        end
    end

    // Colon phase flips on every change of the live seconds value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_q <= 6'd0;
            r_colon <= 1'b1;
        end else begin
            r_sec_q <= bus.sec_in;
            if (bus.sec_in != r_sec_q) begin
                r_colon <= ~r_colon;
            end
        end
    end

    // r_armed masks the first cycle after reset so a level already high cannot ring
    assign w_alarm_rise = r_armed & bus.alarm_in & ~r_alarm_q;
    assign w_alarm_fall = r_armed & ~bus.alarm_in & r_alarm_q;
    assign w_ack_rise   = r_armed & bus.ack & ~r_ack_q;

    // Alarm annunciator state machine with tone generator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_alarm_q <= 1'b0;
            r_ack_q   <= 1'b0;
            r_armed   <= 1'b0;
            r_tone    <= '0;
            r_buzzer  <= 1'b0;
        end else begin
            r_alarm_q <= bus.alarm_in;
            r_ack_q   <= bus.ack;
            r_armed   <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_alarm_rise) r_state <= ST_RINGING;
                end
                ST_RINGING: begin
                    if (w_alarm_fall)    r_state <= ST_IDLE;
                    else if (w_ack_rise) r_state <= ST_ACKED;
                end
                ST_ACKED: begin
                    if (w_alarm_fall) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (r_state == ST_RINGING) begin
                if (r_tone == '0) r_buzzer <= ~r_buzzer;
                r_tone <= (r_tone == TONE_LAST) ? '0 : r_tone + 1'b1;
            end else begin
                r_tone   <= '0;
                r_buzzer <= 1'b0;
            end
        end
    end

    assign bus.digit_sel = r_digit_sel;
    assign bus.seg       = r_seg;
    assign bus.dp        = r_dp;
    assign bus.buzzer    = r_buzzer;

endmodule
